// File: rtl/xadc_temp_monitor.sv
// XADC temperature monitor: channel filter, box-car average, hysteretic alarm and stale watchdog.
// Define XADC_MINMAX_EN to add the temp_min/temp_max trackers.
module xadc_temp_monitor #(
    parameter logic [4:0]  CHANNEL        = 5'd0,
    parameter int          AVG_LOG2       = 3,
    parameter logic [11:0] ALARM_HI       = 12'hC00,
    parameter logic [11:0] ALARM_LO       = 12'hB80,
    parameter int          TIMEOUT_CYCLES = 4000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        drdy_in,
    input  logic [4:0]  channel_in,
    input  logic [15:0] do_in,
    input  logic        clear_alarm,
    output logic [11:0] xadc_avg_out,
    output logic        avg_valid,
    output logic        over_temp,
    output logic        stale,
    output logic [6:0]  sample_cnt
`ifdef XADC_MINMAX_EN
    ,
    output logic [11:0] temp_min,
    output logic [11:0] temp_max
`endif
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [6:0]      LAST_CNT = 7'((1 << AVG_LOG2) - 1);
    localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_PRE   = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_ACCUM,
        ST_PUBLISH
    } state_t;

    state_t            state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg;
    logic [6:0]        sample_cnt_reg;
    logic [11:0]       avg_reg;
    logic              over_temp_reg, over_temp_next;
    logic [WD_W-1:0]   wd_reg;
    logic              stale_reg;

    logic              accept;
    logic              close;
    logic [11:0]       sample;
    logic [ACC_W-1:0]  acc_sum;
    logic [11:0]       avg_next;
    logic              unused_lsbs;

    assign sample      = do_in[15:4];
    assign unused_lsbs = ^do_in[3:0];
    assign accept      = drdy_in && (channel_in == CHANNEL);
    assign close       = accept && (sample_cnt_reg == LAST_CNT);
    assign acc_sum     = acc_reg + ACC_W'(sample);
    assign avg_next    = 12'(acc_sum >> AVG_LOG2);

    // A close while still publishing (AVG_LOG2=0) stays in PUBLISH so no average goes unflagged
    always_comb begin
        state_next     = ST_ACCUM;
        over_temp_next = over_temp_reg;
        case (state_reg)
            ST_ACCUM: begin
                if (close)
                    state_next = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                if (close)
                    state_next = ST_PUBLISH;
                if (!over_temp_reg && (avg_reg >= ALARM_HI))
                    over_temp_next = 1'b1;
                else if (over_temp_reg && (avg_reg < ALARM_LO))
                    over_temp_next = 1'b0;
            end
            default: state_next = ST_ACCUM;
        endcase
        if (clear_alarm)
            over_temp_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_ACCUM;
            acc_reg        <= '0;
            sample_cnt_reg <= '0;
            avg_reg        <= '0;
            over_temp_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            over_temp_reg <= over_temp_next;
            if (accept) begin
                if (close) begin
                    acc_reg        <= '0;
                    sample_cnt_reg <= '0;
                    avg_reg        <= avg_next;
                end else begin
                    acc_reg        <= acc_sum;
                    sample_cnt_reg <= sample_cnt_reg + 7'd1;
                end
            end
        end
    end

    // Watchdog saturates at the timeout; stale rises together with the count reaching it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_reg    <= '0;
            stale_reg <= 1'b0;
        end else if (accept) begin
            wd_reg    <= '0;
            stale_reg <= 1'b0;
        end else if (wd_reg != WD_MAX) begin
            wd_reg <= wd_reg + 1'b1;
            if (wd_reg == WD_PRE)
                stale_reg <= 1'b1;
        end
    end

`ifdef XADC_MINMAX_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            temp_min <= 12'hFFF;
            temp_max <= 12'h000;
        end else if (clear_alarm) begin
            temp_min <= 12'hFFF;
            temp_max <= 12'h000;
        end else if (state_reg == ST_PUBLISH) begin
            if (avg_reg < temp_min)
                temp_min <= avg_reg;
            if (avg_reg > temp_max)
                temp_max <= avg_reg;
        end
    end
`endif

    assign xadc_avg_out = avg_reg;
    assign avg_valid    = (state_reg == ST_PUBLISH);
    assign over_temp    = over_temp_reg;
    assign stale        = stale_reg;
    assign sample_cnt   = sample_cnt_reg;

endmodule

// File: tb/tb_xadc_temp_monitor.sv
// Bench for xadc_temp_monitor: directed scenarios plus randomized traffic against a queue-based model.
module tb_xadc_temp_monitor;

    localparam int          AVG_LOG2 = 2;
    localparam int          N        = 4;
    localparam int          T        = 100;
    localparam logic [11:0] HI       = 12'hC00;
    localparam logic [11:0] LO       = 12'hB80;

    logic        clk;
    logic        rst;
    logic        drdy_in;
    logic [4:0]  channel_in;
    logic [15:0] do_in;
    logic        clear_alarm;
    logic [11:0] xadc_avg_out;
    logic        avg_valid;
    logic        over_temp;
    logic        stale;
    logic [6:0]  sample_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          q[$];
    logic [11:0] m_avg;
    bit          m_valid;
    bit          m_alarm;
    bit          m_stale;
    int          m_since;

    xadc_temp_monitor #(
        .CHANNEL        (5'd0),
        .AVG_LOG2       (AVG_LOG2),
        .ALARM_HI       (HI),
        .ALARM_LO       (LO),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .drdy_in      (drdy_in),
        .channel_in   (channel_in),
        .do_in        (do_in),
        .clear_alarm  (clear_alarm),
        .xadc_avg_out (xadc_avg_out),
        .avg_valid    (avg_valid),
        .over_temp    (over_temp),
        .stale        (stale),
        .sample_cnt   (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_avg   = 12'h000;
        m_valid = 1'b0;
        m_alarm = 1'b0;
        m_stale = 1'b0;
        m_since = 0;
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle 1 time unit
    task automatic step(input bit d, input logic [4:0] ch, input logic [11:0] code, input bit clr);
        bit acc;
        int s;
        drdy_in     = d;
        channel_in  = ch;
        do_in       = {code, 4'($urandom)};
        clear_alarm = clr;
        @(posedge clk);
        acc = d && (ch == 5'd0);
        if (clr)
            m_alarm = 1'b0;
        else if (m_valid) begin
            if (!m_alarm && m_avg >= HI)
                m_alarm = 1'b1;
            else if (m_alarm && m_avg < LO)
                m_alarm = 1'b0;
        end
        m_valid = 1'b0;
        if (acc) begin
            q.push_back(int'(code));
            if (q.size() == N) begin
                s = 0;
                foreach (q[i]) s += q[i];
                m_avg   = 12'(s / N);
                m_valid = 1'b1;
                q.delete();
                $display("txn: t=%0t published avg=0x%03h", $time, m_avg);
            end
            m_since = 0;
            m_stale = 1'b0;
        end else begin
            if (m_since < T)
                m_since++;
            m_stale = (m_since >= T);
        end
        #1;
        drdy_in     = 1'b0;
        clear_alarm = 1'b0;
    endtask

    task automatic publish(input logic [11:0] v);
        for (int i = 0; i < N; i++) step(1'b1, 5'd0, v, 1'b0);
        step(1'b0, 5'd0, 12'h000, 1'b0);
    endtask

    task automatic test_reset();
        total++; if (xadc_avg_out !== 12'h000) begin bad++; $display("FAIL reset_avg actual=%h required=000", xadc_avg_out); end
        total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid actual=%b required=0", avg_valid); end
        total++; if (over_temp !== 1'b0) begin bad++; $display("FAIL reset_over_temp actual=%b required=0", over_temp); end
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL reset_stale actual=%b required=0", stale); end
        total++; if (sample_cnt !== 7'd0) begin bad++; $display("FAIL reset_cnt actual=%0d required=0", sample_cnt); end
    endtask

    task automatic test_averaging();
        for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 12'(100 + i), 1'b0);
        total++; if (sample_cnt !== 7'd3) begin bad++; $display("FAIL avg_cnt3 actual=%0d required=3", sample_cnt); end
        total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL avg_early_valid actual=%b required=0", avg_valid); end
        step(1'b1, 5'd0, 12'd103, 1'b0);
        total++; if (xadc_avg_out !== 12'd101) begin bad++; $display("FAIL avg_value actual=%0d required=101", xadc_avg_out); end
        total++; if (avg_valid !== 1'b1) begin bad++; $display("FAIL avg_valid actual=%b required=1", avg_valid); end
        total++; if (sample_cnt !== 7'd0) begin bad++; $display("FAIL avg_cnt0 actual=%0d required=0", sample_cnt); end
        step(1'b0, 5'd0, 12'h000, 1'b0);
        total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL avg_valid_once actual=%b required=0", avg_valid); end
        total++; if (xadc_avg_out !== 12'd101) begin bad++; $display("FAIL avg_hold actual=%0d required=101", xadc_avg_out); end
    endtask

    task automatic test_channel_filter();
        for (int i = 0; i < N; i++) begin
            step(1'b1, 5'd0, 12'h800, 1'b0);
            if (i < N - 1) step(1'b1, 5'd3, 12'hFFF, 1'b0);
        end
        total++; if (xadc_avg_out !== 12'h800) begin bad++; $display("FAIL chan_avg actual=%h required=800", xadc_avg_out); end
        total++; if (avg_valid !== 1'b1) begin bad++; $display("FAIL chan_valid actual=%b required=1", avg_valid); end
        step(1'b1, 5'd3, 12'hFFF, 1'b0);
        total++; if (sample_cnt !== 7'd0) begin bad++; $display("FAIL chan_cnt actual=%0d required=0", sample_cnt); end
    endtask

    task automatic test_hysteresis();
        for (int i = 0; i < N; i++) step(1'b1, 5'd0, 12'hC00, 1'b0);
        total++; if (over_temp !== 1'b0) begin bad++; $display("FAIL hyst_latency actual=%b required=0", over_temp); end
        step(1'b0, 5'd0, 12'h000, 1'b0);
        total++; if (over_temp !== 1'b1) begin bad++; $display("FAIL hyst_set_c00 actual=%b required=1", over_temp); end
        publish(12'hBA0);
        total++; if (over_temp !== 1'b1) begin bad++; $display("FAIL hyst_hold_ba0 actual=%b required=1", over_temp); end
        publish(12'hB7F);
        total++; if (over_temp !== 1'b0) begin bad++; $display("FAIL hyst_clr_b7f actual=%b required=0", over_temp); end
        publish(12'hBFF);
        total++; if (over_temp !== 1'b0) begin bad++; $display("FAIL hyst_hold_bff actual=%b required=0", over_temp); end
    endtask

    task automatic test_clear_alarm();
        publish(12'hC00);
        total++; if (over_temp !== 1'b1) begin bad++; $display("FAIL clr_pre actual=%b required=1", over_temp); end
        step(1'b0, 5'd0, 12'h000, 1'b1);
        total++; if (over_temp !== 1'b0) begin bad++; $display("FAIL clr_force actual=%b required=0", over_temp); end
        publish(12'hC10);
        total++; if (over_temp !== 1'b1) begin bad++; $display("FAIL clr_reset actual=%b required=1", over_temp); end
    endtask

    task automatic test_watchdog();
        publish(12'h900);
        // 98 more cycles, half carrying ignored channel-3 strobes, brings the count to 99
        for (int i = 0; i < T - 2; i++) step((i % 2) == 1, 5'd3, 12'hFFF, 1'b0);
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL wd_early actual=%b required=0", stale); end
        step(1'b0, 5'd0, 12'h000, 1'b0);
        total++; if (stale !== 1'b1) begin bad++; $display("FAIL wd_stale actual=%b required=1", stale); end
        total++; if (xadc_avg_out !== 12'h900) begin bad++; $display("FAIL wd_avg_hold actual=%h required=900", xadc_avg_out); end
        for (int i = 0; i < 5; i++) step(1'b1, 5'd2, 12'h123, 1'b0);
        total++; if (stale !== 1'b1) begin bad++; $display("FAIL wd_stay actual=%b required=1", stale); end
        step(1'b1, 5'd0, 12'h900, 1'b0);
        total++; if (stale !== 1'b0) begin bad++; $display("FAIL wd_recover actual=%b required=0", stale); end
        total++; if (sample_cnt !== 7'd1) begin bad++; $display("FAIL wd_cnt actual=%0d required=1", sample_cnt); end
        for (int i = 0; i < N - 1; i++) step(1'b1, 5'd0, 12'h900, 1'b0);
        step(1'b0, 5'd0, 12'h000, 1'b0);
    endtask

    task automatic test_reset_mid_window();
        step(1'b1, 5'd0, 12'h700, 1'b0);
        step(1'b1, 5'd0, 12'h700, 1'b0);
        #2 rst = 1'b0;
        #1;
        total++; if (xadc_avg_out !== 12'h000) begin bad++; $display("FAIL rmw_avg actual=%h required=000", xadc_avg_out); end
        total++; if (sample_cnt !== 7'd0) begin bad++; $display("FAIL rmw_cnt actual=%0d required=0", sample_cnt); end
        total++; if (over_temp !== 1'b0 || stale !== 1'b0 || avg_valid !== 1'b0) begin
            bad++; $display("FAIL rmw_flags actual=%b%b%b required=000", over_temp, stale, avg_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) step(1'b1, 5'd0, 12'h400, 1'b0);
        total++; if (xadc_avg_out !== 12'h400) begin bad++; $display("FAIL rmw_after actual=%h required=400", xadc_avg_out); end
        step(1'b0, 5'd0, 12'h000, 1'b0);
    endtask

    task automatic test_random();
        bit          d;
        bit          clr;
        logic [4:0]  ch;
        logic [11:0] code;
        for (int i = 0; i < 400; i++) begin
            d    = ($urandom_range(0, 2) == 0);
            ch   = ($urandom_range(0, 3) == 0) ? 5'd3 : 5'd0;
            code = 12'(12'hB00 + $urandom_range(0, 12'h1FF));
            clr  = ($urandom_range(0, 39) == 0);
            step(d, ch, code, clr);
            total++; if (xadc_avg_out !== m_avg) begin bad++; $display("FAIL rnd_avg cyc=%0d actual=%h required=%h", i, xadc_avg_out, m_avg); end
            total++; if (avg_valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d actual=%b required=%b", i, avg_valid, m_valid); end
            total++; if (over_temp !== m_alarm) begin bad++; $display("FAIL rnd_over_temp cyc=%0d actual=%b required=%b", i, over_temp, m_alarm); end
            total++; if (stale !== m_stale) begin bad++; $display("FAIL rnd_stale cyc=%0d actual=%b required=%b", i, stale, m_stale); end
            total++; if (sample_cnt !== 7'(q.size())) begin bad++; $display("FAIL rnd_cnt cyc=%0d actual=%0d required=%0d", i, sample_cnt, q.size()); end
        end
    endtask

    initial begin
        rst         = 1'b0;
        drdy_in     = 1'b0;
        channel_in  = 5'd0;
        do_in       = 16'h0000;
        clear_alarm = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_averaging();
        test_channel_filter();
        test_hysteresis();
        test_clear_alarm();
        test_watchdog();
        test_reset_mid_window();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

endmodule
